// File: rtl/halfband_interp_if.sv
// Sample-stream bundle for halfband_interp: input strobe/data, output strobe/data,
// sticky overrun flag and the FSM state for debug.
interface halfband_interp_if;
  // Strobe semantics: a sample moves only in a cycle where its strobe is high.
  // There is no back-pressure; a strobe_in that arrives while the block is busy
  // is dropped and recorded in overrun.
  logic               enable;
  logic               strobe_in;
  logic signed [15:0] data_in;
  logic               strobe_out;
  logic signed [15:0] data_out;
  logic               overrun;
  logic [1:0]         fsm_state;

  modport master (
    output enable, strobe_in, data_in,
    input  strobe_out, data_out, overrun, fsm_state
  );

  modport slave (
    input  enable, strobe_in, data_in,
    output strobe_out, data_out, overrun, fsm_state
  );
endinterface

// File: rtl/halfband_interp.sv
// 2x interpolator built on a 31-tap halfband FIR with a serial MAC for the odd phase.
// Define HBI_SATURATE_EN to clamp the odd output instead of wrapping it.
module halfband_interp (
  input  logic              clock,
  input  logic              reset,
  halfband_interp_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MAC = 2'd1, S_FLUSH = 2'd2, S_ROUND = 2'd3} state_t;

  state_t             state, state_nxt;
  logic signed [15:0] dly [16];
  logic [2:0]         tap;
  logic [3:0]         tap_mirror;
  logic signed [16:0] pre_add;
  logic signed [15:0] coef;
  logic signed [32:0] prod_q;
  logic               prod_vld;
  logic signed [35:0] acc;
  logic               odd_out_q;
  logic signed [15:0] odd_res;
  logic               accept, drop, mac_step, round_fire;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (!bus.enable) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (accept) state_nxt = S_MAC;
        S_MAC:   if (tap == 3'd7) state_nxt = S_FLUSH;
        S_FLUSH: state_nxt = S_ROUND;
        S_ROUND: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Output/control decode; the cycle carrying the odd strobe still counts as busy
  always_comb begin
    accept     = 1'b0;
    drop       = 1'b0;
    mac_step   = 1'b0;
    round_fire = 1'b0;
    if (bus.enable) begin
      accept     = bus.strobe_in && (state == S_IDLE) && !odd_out_q;
      drop       = bus.strobe_in && ((state != S_IDLE) || odd_out_q);
      mac_step   = (state == S_MAC);
      round_fire = (state == S_ROUND);
    end
  end

  assign bus.fsm_state = state;

  always_comb begin
    case (tap)
      3'd0:    coef = -16'sd49;
      3'd1:    coef = 16'sd165;
      3'd2:    coef = -16'sd412;
      3'd3:    coef = 16'sd873;
      3'd4:    coef = -16'sd1681;
      3'd5:    coef = 16'sd3135;
      3'd6:    coef = -16'sd6282;
      default: coef = 16'sd20628;
    endcase
  end

  assign tap_mirror = 4'd15 - {1'b0, tap};
  assign pre_add    = {dly[{1'b0, tap}][15], dly[{1'b0, tap}]} + {dly[tap_mirror][15], dly[tap_mirror]};

  // Round half up at bit 14, then keep the integer part
`ifdef HBI_SATURATE_EN
  logic signed [20:0] odd_full;
  assign odd_full = 21'((acc + 36'sd16384) >>> 15);
  always_comb begin
    if (odd_full > 21'sd32767)       odd_res = 16'sh7fff;
    else if (odd_full < -21'sd32768) odd_res = 16'sh8000;
    else                             odd_res = odd_full[15:0];
  end
`else
  assign odd_res = 16'((acc + 36'sd16384) >>> 15);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) dly[i] <= '0;
      tap      <= '0;
      prod_q   <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else begin
      if (accept) begin
        dly[0] <= bus.data_in;
        for (int i = 1; i < 16; i++) dly[i] <= dly[i-1];
      end
      if (accept)        tap <= '0;
      else if (mac_step) tap <= tap + 3'd1;
      if (mac_step) prod_q <= coef * pre_add;
      prod_vld <= mac_step;
      if (accept)        acc <= '0;
      else if (prod_vld) acc <= acc + {{3{prod_q[32]}}, prod_q};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.strobe_out <= 1'b0;
      bus.data_out   <= '0;
      bus.overrun    <= 1'b0;
      odd_out_q      <= 1'b0;
    end else begin
      bus.strobe_out <= accept || round_fire;
      odd_out_q      <= round_fire;
      if (accept)          bus.data_out <= dly[7];
      else if (round_fire) bus.data_out <= odd_res;
      if (drop) bus.overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_halfband_interp.sv
// Self-checking bench for halfband_interp: reference model feeds an expected queue,
// a negedge monitor pops and compares every output strobe.
module tb_halfband_interp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  halfband_interp_if bus ();

  halfband_interp u_dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  int          mdl[16];
  int          coef[8] = '{-49, 165, -412, 873, -1681, 3135, -6282, 20628};
  int          odd_tbl[16] = '{-24, 83, -206, 437, -840, 1568, -3141, 10314,
                               10314, -3141, 1568, -840, 437, -206, 83, -24};
  logic        prev_strobe = 1'b0;

  function automatic logic [15:0] model_odd();
    longint acc = 0;
    longint r;
    for (int k = 0; k < 8; k++)
      acc += longint'(coef[k]) * longint'(mdl[k] + mdl[15-k]);
    r = (acc + 64'sd16384) >>> 15;
`ifdef HBI_SATURATE_EN
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  task automatic model_push(input logic signed [15:0] d);
    for (int i = 15; i > 0; i--) mdl[i] = mdl[i-1];
    mdl[0] = d;
    exp_q.push_back(mdl[8][15:0]);
    exp_q.push_back(model_odd());
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mdl[i] = 0;
    exp_q.delete();
  endtask

  // Called at a negedge; strobe is high for exactly one cycle.
  task automatic send(input logic [15:0] d, input bit accept);
    bus.data_in   = d;
    bus.strobe_in = 1'b1;
    if (accept) model_push(d);
    @(negedge clk);
    bus.strobe_in = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_clear();
    wait_cycles(2);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      prev_strobe = 1'b0;
    end else begin
      if (bus.strobe_out) begin
        checks++;
        if (prev_strobe) begin
          errors++;
          $display("FAIL strobe_consecutive: strobe_out high two cycles in a row at %0t", $time);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: data_out=%0d with no expected sample at %0t",
                   $signed(bus.data_out), $time);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (bus.data_out !== e) begin
            errors++;
            $display("FAIL sample: got %0d expected %0d at %0t", $signed(bus.data_out), $signed(e), $time);
          end
        end
      end
      prev_strobe = bus.strobe_out;
    end
  end

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: %0d expected samples never appeared", name, exp_q.size());
    end
  endtask

  task automatic check_overrun(input string name, input logic exp);
    checks++;
    if (bus.overrun !== exp) begin
      errors++;
      $display("FAIL %s_overrun: got %b expected %b", name, bus.overrun, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_clear();
    wait_cycles(3);
    checks++;
    if (bus.data_out !== 16'd0 || bus.strobe_out !== 1'b0 || bus.overrun !== 1'b0 || bus.fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: data_out=%0d strobe_out=%b overrun=%b fsm=%0d expected 0/0/0/0",
               $signed(bus.data_out), bus.strobe_out, bus.overrun, bus.fsm_state);
    end
    rst = 1'b0;
    wait_cycles(3);
    checks++;
    if (bus.strobe_out !== 1'b0 || bus.data_out !== 16'd0) begin
      errors++;
      $display("FAIL reset_release: strobe_out=%b data_out=%0d expected 0/0", bus.strobe_out, $signed(bus.data_out));
    end
  endtask

  task automatic run_impulse(input string name);
    for (int i = 0; i < 16; i++) begin
      send((i == 0) ? 16'd16384 : 16'd0, 1'b1);
      checks++;
      if (bus.strobe_out !== 1'b1 || $signed(bus.data_out) !== ((i == 8) ? 16384 : 0)) begin
        errors++;
        $display("FAIL %s_even[%0d]: strobe=%b data=%0d expected 1/%0d", name, i, bus.strobe_out,
                 $signed(bus.data_out), (i == 8) ? 16384 : 0);
      end
      wait_cycles(10);
      checks++;
      if (bus.strobe_out !== 1'b1 || $signed(bus.data_out) !== odd_tbl[i]) begin
        errors++;
        $display("FAIL %s_odd[%0d]: strobe=%b data=%0d expected 1/%0d", name, i, bus.strobe_out,
                 $signed(bus.data_out), odd_tbl[i]);
      end
      wait_cycles(5);
    end
    check_drained(name);
  endtask

  task automatic test_impulse();
    apply_reset();
    run_impulse("impulse");
    check_overrun("impulse", 1'b0);
  endtask

  task automatic test_back_to_back_dc();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      send(16'd16384, 1'b1);
      if (i >= 8) begin
        checks++;
        if ($signed(bus.data_out) !== 16384) begin
          errors++;
          $display("FAIL dc_even[%0d]: got %0d expected 16384", i, $signed(bus.data_out));
        end
      end
      wait_cycles(10);
      if (i >= 15) begin
        checks++;
        if ($signed(bus.data_out) !== 16377) begin
          errors++;
          $display("FAIL dc_odd[%0d]: got %0d expected 16377", i, $signed(bus.data_out));
        end
      end
      wait_cycles(1);
    end
    check_drained("dc");
    check_overrun("dc_min_spacing", 1'b0);
  endtask

  task automatic test_worst_case();
    int exp_odd;
    apply_reset();
`ifdef HBI_SATURATE_EN
    exp_odd = 32767;
`else
    exp_odd = 912;
`endif
    for (int j = 0; j < 16; j++) begin
      int m;
      int c;
      m = 15 - j;
      c = (m < 8) ? coef[m] : coef[15-m];
      send((c > 0) ? 16'sd32767 : -16'sd32767, 1'b1);
      wait_cycles(10);
      if (j == 15) begin
        checks++;
        if ($signed(bus.data_out) !== exp_odd) begin
          errors++;
          $display("FAIL worst_odd: got %0d expected %0d", $signed(bus.data_out), exp_odd);
        end
      end
      wait_cycles(1);
    end
    check_drained("worst");
  endtask

  task automatic test_overrun();
    apply_reset();
    send(16'd1000, 1'b1);
    wait_cycles(4);
    send(16'd2000, 1'b0);
    wait_cycles(8);
    check_drained("overrun");
    check_overrun("overrun_set", 1'b1);
    wait_cycles(20);
    check_overrun("overrun_sticky", 1'b1);
    // Spacing of 11 still lands in the busy window
    apply_reset();
    check_overrun("overrun_cleared", 1'b0);
    send(16'd777, 1'b1);
    wait_cycles(10);
    send(16'd555, 1'b0);
    wait_cycles(15);
    check_drained("spacing11");
    check_overrun("spacing11", 1'b1);
  endtask

  task automatic test_reset_mid_mac();
    apply_reset();
    send(16'd16384, 1'b1);
    wait_cycles(3);
    rst = 1'b1;
    void'(exp_q.pop_back());
    for (int i = 0; i < 16; i++) mdl[i] = 0;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(20);
    checks++;
    if (bus.data_out !== 16'd0 || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: data_out=%0d overrun=%b expected 0/0", $signed(bus.data_out), bus.overrun);
    end
    check_drained("midreset");
    run_impulse("midreset_impulse");
  endtask

  task automatic test_enable();
    logic [15:0] exp_even;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      send(16'($urandom_range(65535, 0)), 1'b1);
      wait_cycles(11);
    end
    send(16'($urandom_range(65535, 0)), 1'b1);
    exp_even = mdl[8][15:0];
    wait_cycles(2);
    bus.enable = 1'b0;
    void'(exp_q.pop_back());
    wait_cycles(15);
    checks++;
    if (bus.data_out !== exp_even || bus.fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL enable_hold: data_out=%0d fsm=%0d expected %0d/0", $signed(bus.data_out),
               bus.fsm_state, $signed(exp_even));
    end
    send(16'd1234, 1'b0);
    wait_cycles(12);
    check_overrun("enable_low_strobe", 1'b0);
    checks++;
    if (bus.data_out !== exp_even) begin
      errors++;
      $display("FAIL enable_low_data: got %0d expected %0d", $signed(bus.data_out), $signed(exp_even));
    end
    bus.enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      send(16'($urandom_range(65535, 0)), 1'b1);
      wait_cycles(11);
    end
    check_drained("enable_resume");
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 30; i++) begin
      send(16'($urandom_range(65535, 0)), 1'b1);
      wait_cycles(int'($urandom_range(20, 12)) - 1);
    end
    wait_cycles(12);
    check_drained("random");
    check_overrun("random", 1'b0);
  endtask

  initial begin
    bus.enable    = 1'b1;
    bus.strobe_in = 1'b0;
    bus.data_in   = '0;
    test_reset();
    test_impulse();
    test_back_to_back_dc();
    test_worst_case();
    test_overrun();
    test_reset_mid_mac();
    test_enable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
